// File: rtl/cw305_usb_reg_responder.sv
// cw305_usb_reg_responder
//
// FPGA-side target of the CW305 USB host parallel register bus. The host
// performs byte-wide write_byte/read_byte transactions using active-low
// strobes (usb_cen, usb_wrn, usb_rdn). This block registers those strobes
// in the usb_clk domain, splits the host address into a register select and
// a byte index, issues single-cycle read/write requests to the register
// file, and drives read data back to the pads along with an output enable.
//
// Ports:
//   usb_clk        sole clock, rising edge
//   rst_n          asynchronous active-low reset
//   usb_addr       host address (register select + byte index)
//   usb_din        host write data from the pad input buffer
//   usb_rdn        host read strobe, active-low
//   usb_wrn        host write strobe, active-low
//   usb_cen        host chip enable, active-low
//   usb_dout       read data to the pad output buffer
//   usb_isout      pad output enable (1 = FPGA drives the data bus)
//   reg_address    register select (upper address bits)
//   reg_bytecnt    byte index within the register (lower address bits)
//   reg_datao      captured host write data
//   reg_datai      register file read data, combinational on the address
//   reg_addrvalid  high while a host cycle is in progress
//   reg_read       one-cycle read request
//   reg_write      one-cycle write commit
//   proto_err      sticky protocol-error flag, cleared only by reset

module cw305_usb_reg_responder #(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7
) (
  input  logic                                 usb_clk,
  input  logic                                 rst_n,
  input  logic [pADDR_WIDTH-1:0]               usb_addr,
  input  logic [7:0]                           usb_din,
  input  logic                                 usb_rdn,
  input  logic                                 usb_wrn,
  input  logic                                 usb_cen,
  output logic [7:0]                           usb_dout,
  output logic                                 usb_isout,
  output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
  output logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
  output logic [7:0]                           reg_datao,
  input  logic [7:0]                           reg_datai,
  output logic                                 reg_addrvalid,
  output logic                                 reg_read,
  output logic                                 reg_write,
  output logic                                 proto_err
);

  localparam int RegW = pADDR_WIDTH - pBYTECNT_SIZE;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_HOLD  = 2'd1,
    RD_DRIVE = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  // Input sample stage. The host bus is asynchronous to usb_clk in general,
  // so every decision below is taken on these registered copies only. The
  // strobes reset to their inactive (high) level so that a host holding cen
  // low across reset looks like a fresh assertion once reset is released.
  logic [pADDR_WIDTH-1:0] s_addr_q;
  logic [7:0]             s_din_q;
  logic                   s_rdn_q;
  logic                   s_wrn_q;
  logic                   s_cen_q;

  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      s_addr_q <= '0;
      s_din_q  <= '0;
      s_rdn_q  <= 1'b1;
      s_wrn_q  <= 1'b1;
      s_cen_q  <= 1'b1;
    end else begin
      s_addr_q <= usb_addr;
      s_din_q  <= usb_din;
      s_rdn_q  <= usb_rdn;
      s_wrn_q  <= usb_wrn;
      s_cen_q  <= usb_cen;
    end
  end

  // Registered outputs of the transaction state machine.
  state_e                 state_q;
  logic [RegW-1:0]        reg_address_q;
  logic [pBYTECNT_SIZE-1:0] reg_bytecnt_q;
  logic [7:0]             reg_datao_q;
  logic [7:0]             usb_dout_q;
  logic                   usb_isout_q;
  logic                   reg_addrvalid_q;
  logic                   reg_read_q;
  logic                   reg_write_q;
  logic                   proto_err_q;

  // Transaction state machine.
  //
  // IDLE waits for a chip-enabled strobe. A write strobe always wins over a
  // read strobe; seeing both together is flagged as a protocol error.
  // WR_HOLD absorbs the rest of a write cycle so that a long cen/wrn low
  // period commits exactly once. RD_DRIVE first spends one cycle with
  // reg_read high (the register file answers combinationally), then captures
  // reg_datai into usb_dout on the following edge and holds it while the
  // host keeps rdn low. RELEASE waits for the bus to go fully idle before
  // another cycle can start.
  //
  // reg_read and reg_write default low every edge, which is what makes them
  // single-cycle pulses.
  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      reg_address_q   <= '0;
      reg_bytecnt_q   <= '0;
      reg_datao_q     <= '0;
      usb_dout_q      <= '0;
      usb_isout_q     <= 1'b0;
      reg_addrvalid_q <= 1'b0;
      reg_read_q      <= 1'b0;
      reg_write_q     <= 1'b0;
      proto_err_q     <= 1'b0;
    end else begin
      reg_read_q  <= 1'b0;
      reg_write_q <= 1'b0;

      case (state_q)
        IDLE: begin
          usb_isout_q <= 1'b0;
          if (!s_cen_q && !s_wrn_q) begin
            reg_address_q   <= s_addr_q[pADDR_WIDTH-1:pBYTECNT_SIZE];
            reg_bytecnt_q   <= s_addr_q[pBYTECNT_SIZE-1:0];
            reg_datao_q     <= s_din_q;
            reg_write_q     <= 1'b1;
            reg_addrvalid_q <= 1'b1;
            if (!s_rdn_q) begin
              proto_err_q <= 1'b1;
            end
            state_q <= WR_HOLD;
          end else if (!s_cen_q && !s_rdn_q) begin
            reg_address_q   <= s_addr_q[pADDR_WIDTH-1:pBYTECNT_SIZE];
            reg_bytecnt_q   <= s_addr_q[pBYTECNT_SIZE-1:0];
            reg_read_q      <= 1'b1;
            reg_addrvalid_q <= 1'b1;
            state_q         <= RD_DRIVE;
          end
        end

        WR_HOLD: begin
          if (s_cen_q && s_wrn_q) begin
            reg_addrvalid_q <= 1'b0;
            state_q         <= IDLE;
          end
        end

        RD_DRIVE: begin
          if (!s_wrn_q) begin
            // A write strobe during a read is illegal: stop driving the bus
            // immediately and never turn it into a register write.
            usb_isout_q     <= 1'b0;
            proto_err_q     <= 1'b1;
            reg_addrvalid_q <= 1'b0;
            state_q         <= RELEASE;
          end else if (s_rdn_q || s_cen_q) begin
            usb_isout_q     <= 1'b0;
            reg_addrvalid_q <= 1'b0;
            state_q         <= RELEASE;
          end else if (reg_read_q) begin
            // Only the first RD_DRIVE cycle captures, so the data presented
            // to the host stays constant for the rest of the strobe.
            usb_dout_q  <= reg_datai;
            usb_isout_q <= 1'b1;
          end
        end

        RELEASE: begin
          reg_addrvalid_q <= 1'b0;
          usb_isout_q     <= 1'b0;
          if (s_cen_q && s_rdn_q && s_wrn_q) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign usb_dout      = usb_dout_q;
  assign usb_isout     = usb_isout_q;
  assign reg_address   = reg_address_q;
  assign reg_bytecnt   = reg_bytecnt_q;
  assign reg_datao     = reg_datao_q;
  assign reg_addrvalid = reg_addrvalid_q;
  assign reg_read      = reg_read_q;
  assign reg_write     = reg_write_q;
  assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_cw305_usb_reg_responder.sv
// Testbench for cw305_usb_reg_responder.
//
// A small register file (16 registers x 16 bytes) answers reg_datai and
// absorbs reg_write commits. Host transactions push their expected effect
// into a queue; a monitor on the falling edge pops an entry whenever the
// DUT commits a write or starts driving read data, and compares it.

module tb_cw305_usb_reg_responder;

  localparam int AW = 21;
  localparam int BC = 7;

  logic            usb_clk = 1'b0;
  logic            rst_n   = 1'b0;
  logic [AW-1:0]   usb_addr = '0;
  logic [7:0]      usb_din  = '0;
  logic            usb_rdn  = 1'b1;
  logic            usb_wrn  = 1'b1;
  logic            usb_cen  = 1'b1;
  logic [7:0]      usb_dout;
  logic            usb_isout;
  logic [AW-BC-1:0] reg_address;
  logic [BC-1:0]   reg_bytecnt;
  logic [7:0]      reg_datao;
  logic [7:0]      reg_datai;
  logic            reg_addrvalid;
  logic            reg_read;
  logic            reg_write;
  logic            proto_err;

  cw305_usb_reg_responder #(.pADDR_WIDTH(AW), .pBYTECNT_SIZE(BC)) dut (
    .usb_clk      (usb_clk),
    .rst_n        (rst_n),
    .usb_addr     (usb_addr),
    .usb_din      (usb_din),
    .usb_rdn      (usb_rdn),
    .usb_wrn      (usb_wrn),
    .usb_cen      (usb_cen),
    .usb_dout     (usb_dout),
    .usb_isout    (usb_isout),
    .reg_address  (reg_address),
    .reg_bytecnt  (reg_bytecnt),
    .reg_datao    (reg_datao),
    .reg_datai    (reg_datai),
    .reg_addrvalid(reg_addrvalid),
    .reg_read     (reg_read),
    .reg_write    (reg_write),
    .proto_err    (proto_err)
  );

  always #5 usb_clk = ~usb_clk;

  // Register file seen by the DUT (the "crypto register block").
  bit [7:0] rf [256];
  assign reg_datai = rf[{reg_address[3:0], reg_bytecnt[3:0]}];
  always @(posedge usb_clk) begin
    if (reg_write) rf[{reg_address[3:0], reg_bytecnt[3:0]}] <= reg_datao;
  end

  // Reference model: what the host believes each byte holds.
  bit [7:0] model [256];

  typedef struct {
    bit            isRead;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } exp_t;
  exp_t expQ[$];

  int compared   = 0;
  int mismatched = 0;
  int wrPulses   = 0;
  int rdPulses   = 0;
  bit isoutSeen  = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: got nothing expected an event", name);
  endtask

  function automatic logic [AW-1:0] makeAddr(input int r, input int b);
    logic [AW-1:0] a;
    a = '0;
    a[AW-1:BC] = r[AW-BC-1:0];
    a[BC-1:0]  = b[BC-1:0];
    return a;
  endfunction

  function automatic int idx(input logic [AW-1:0] a);
    return int'({a[BC+3:BC], a[3:0]});
  endfunction

  // Monitor: pops expectations on DUT-presented events.
  logic       prevRead  = 1'b0;
  logic       prevWrite = 1'b0;
  logic       prevIsout = 1'b0;
  logic [7:0] prevDout  = '0;

  always @(negedge usb_clk) begin
    exp_t e;
    if (!rst_n) begin
      prevRead  = 1'b0;
      prevWrite = 1'b0;
      prevIsout = 1'b0;
    end else begin
      if (reg_write) begin
        wrPulses++;
        checkOutput("reg_write single cycle", prevWrite, 1'b0);
        checkOutput("addrvalid on write", reg_addrvalid, 1'b1);
        if (expQ.size() == 0) failNow("unexpected reg_write");
        else begin
          e = expQ.pop_front();
          checkOutput("write kind", e.isRead, 1'b0);
          checkOutput("write addr", {reg_address, reg_bytecnt}, e.addr);
          checkOutput("write data", reg_datao, e.data);
        end
      end
      if (reg_read) begin
        rdPulses++;
        checkOutput("reg_read single cycle", prevRead, 1'b0);
        checkOutput("addrvalid on read", reg_addrvalid, 1'b1);
      end
      if (usb_isout && !prevIsout) begin
        isoutSeen = 1'b1;
        checkOutput("read latency", prevRead, 1'b1);
        if (expQ.size() == 0) failNow("unexpected read drive");
        else begin
          e = expQ.pop_front();
          checkOutput("read kind", e.isRead, 1'b1);
          checkOutput("read addr", {reg_address, reg_bytecnt}, e.addr);
          checkOutput("read data", usb_dout, e.data);
        end
      end
      if (usb_isout && prevIsout) checkOutput("dout held", usb_dout, prevDout);
      prevRead  = reg_read;
      prevWrite = reg_write;
      prevIsout = usb_isout;
      prevDout  = usb_dout;
    end
  end

  task automatic hostWrite(input logic [AW-1:0] a, input logic [7:0] d, input int hold);
    expQ.push_back('{isRead: 1'b0, addr: a, data: d});
    model[idx(a)] = d;
    @(negedge usb_clk);
    usb_addr = a; usb_din = d; usb_cen = 1'b0; usb_wrn = 1'b0;
    repeat (hold) @(negedge usb_clk);
    usb_cen = 1'b1; usb_wrn = 1'b1;
    repeat (3) @(negedge usb_clk);
  endtask

  task automatic hostRead(input logic [AW-1:0] a, input int hold);
    expQ.push_back('{isRead: 1'b1, addr: a, data: model[idx(a)]});
    @(negedge usb_clk);
    usb_addr = a; usb_cen = 1'b0; usb_rdn = 1'b0;
    repeat (hold) @(negedge usb_clk);
    usb_cen = 1'b1; usb_rdn = 1'b1;
    repeat (3) @(negedge usb_clk);
  endtask

  task automatic applyStimulus(input bit isRead, input logic [AW-1:0] a, input logic [7:0] d, input int hold);
    if (isRead) hostRead(a, hold);
    else hostWrite(a, d, hold);
  endtask

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w0, r0;
    logic [127:0] burst;
    logic [AW-1:0] a;

    repeat (3) @(negedge usb_clk);
    checkOutput("reset usb_isout", usb_isout, 1'b0);
    checkOutput("reset usb_dout", usb_dout, 8'h00);
    checkOutput("reset reg_write", reg_write, 1'b0);
    checkOutput("reset reg_read", reg_read, 1'b0);
    checkOutput("reset addrvalid", reg_addrvalid, 1'b0);
    checkOutput("reset proto_err", proto_err, 1'b0);
    checkOutput("reset reg_address", reg_address, '0);
    rst_n = 1'b1;
    @(negedge usb_clk);

    $display("[TB] single write");
    w0 = wrPulses;
    applyStimulus(1'b0, makeAddr(5, 3), 8'hA5, 3);
    checkOutput("write reg_address", reg_address, 5);
    checkOutput("write reg_bytecnt", reg_bytecnt, 3);
    checkOutput("write reg_datao", reg_datao, 8'hA5);
    checkOutput("write proto_err", proto_err, 1'b0);
    checkOutput("write pulse count", wrPulses - w0, 1);

    $display("[TB] single read");
    applyStimulus(1'b0, makeAddr(7, 0), 8'h3C, 2);
    r0 = rdPulses;
    applyStimulus(1'b1, makeAddr(7, 0), 8'h00, 6);
    checkOutput("read isout released", usb_isout, 1'b0);
    checkOutput("read pulse count", rdPulses - r0, 1);

    $display("[TB] burst write and readback");
    burst = 128'h0123456789ABCDEF_00112233FFFFFFFF;
    w0 = wrPulses; r0 = rdPulses;
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, makeAddr(2, i), burst[8*i +: 8], 2);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, makeAddr(2, i), 8'h00, 4);
    checkOutput("burst write count", wrPulses - w0, 16);
    checkOutput("burst read count", rdPulses - r0, 16);

    $display("[TB] long write strobe");
    w0 = wrPulses;
    applyStimulus(1'b0, makeAddr(9, 1), 8'h5A, 10);
    checkOutput("long write count", wrPulses - w0, 1);

    $display("[TB] simultaneous strobes");
    isoutSeen = 1'b0;
    w0 = wrPulses; r0 = rdPulses;
    a = makeAddr(11, 6);
    expQ.push_back('{isRead: 1'b0, addr: a, data: 8'hC3});
    model[idx(a)] = 8'hC3;
    @(negedge usb_clk);
    usb_addr = a; usb_din = 8'hC3; usb_cen = 1'b0; usb_wrn = 1'b0; usb_rdn = 1'b0;
    repeat (5) @(negedge usb_clk);
    usb_cen = 1'b1; usb_wrn = 1'b1; usb_rdn = 1'b1;
    repeat (4) @(negedge usb_clk);
    checkOutput("simul write count", wrPulses - w0, 1);
    checkOutput("simul read count", rdPulses - r0, 0);
    checkOutput("simul isout seen", isoutSeen, 1'b0);
    checkOutput("simul proto_err", proto_err, 1'b1);
    applyStimulus(1'b1, a, 8'h00, 4);
    checkOutput("proto_err sticky", proto_err, 1'b1);
    rst_n = 1'b0;
    @(negedge usb_clk);
    rst_n = 1'b1;
    @(negedge usb_clk);
    checkOutput("proto_err cleared", proto_err, 1'b0);

    $display("[TB] random traffic");
    for (int n = 0; n < 40; n++) begin
      bit rd;
      rd = $urandom_range(0, 1) == 1;
      a  = makeAddr($urandom_range(0, 15), $urandom_range(0, 15));
      if (rd) applyStimulus(1'b1, a, 8'h00, $urandom_range(4, 8));
      else applyStimulus(1'b0, a, 8'($urandom), $urandom_range(1, 6));
    end
    checkOutput("random proto_err", proto_err, 1'b0);

    $display("[TB] reset during read");
    a = makeAddr(13, 4);
    applyStimulus(1'b0, a, 8'h96, 2);
    expQ.push_back('{isRead: 1'b1, addr: a, data: model[idx(a)]});
    @(negedge usb_clk);
    usb_addr = a; usb_cen = 1'b0; usb_rdn = 1'b0;
    for (int k = 0; k < 20 && !usb_isout; k++) @(negedge usb_clk);
    if (!usb_isout) failNow("isout before reset");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid-read reset isout", usb_isout, 1'b0);
    checkOutput("mid-read reset reg_read", reg_read, 1'b0);
    checkOutput("mid-read reset reg_write", reg_write, 1'b0);
    checkOutput("mid-read reset addrvalid", reg_addrvalid, 1'b0);
    usb_cen = 1'b1; usb_rdn = 1'b1;
    @(negedge usb_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge usb_clk);
    r0 = rdPulses;
    applyStimulus(1'b1, a, 8'h00, 5);
    checkOutput("post-reset read count", rdPulses - r0, 1);

    repeat (5) @(negedge usb_clk);
    checkOutput("queue drained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
